// File: rtl/seq_det_pkg.sv
// Shared types for the serial 10010 detector slice.
// Controller and detector state encodings, pattern constants.
package seq_det_pkg;

  localparam int PAT_LEN = 5;
  localparam logic [PAT_LEN-1:0] PATTERN = 5'b10010;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    REPORT
  } ctrl_state_t;

  typedef enum logic [2:0] {
    S0,
    S1,
    S2,
    S3,
    S4
  } det_state_t;

endpackage

// File: rtl/seq_det_core.sv
// Mealy recognizer for serial 10010 with overlap.
// Ports: clk, reset, flush, bit_en, bit_in -> match.
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic bit_en,
  input  logic bit_in,
  output logic match
);

  det_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    if (flush) begin
      state_d = S0;
    end else if (bit_en) begin
      unique case (state_q)
        S0: state_d = bit_in ? S1 : S0;
        S1: state_d = bit_in ? S1 : S2;
        S2: state_d = bit_in ? S1 : S3;
        S3: state_d = bit_in ? S4 : S0;
        S4: begin
          state_d = bit_in ? S1 : S2;
          match   = !bit_in;
        end
        default: state_d = S0;
      endcase
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-serializing controller around seq_det_core.
// in_* word handshake, out_* per-word count, total_count, busy.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WORD_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [$clog2(WORD_W+1)-1:0]  out_count,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             total_count,
  output logic                         busy
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
  localparam logic [CW-1:0] MAXC = CW'(WORD_W);

  ctrl_state_t       state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  total_q, total_d;

  logic hs;
  logic bit_en;
  logic det_flush;
  logic match;

  assign in_ready    = (state_q == IDLE);
  assign hs          = in_valid && in_ready;
  assign bit_en      = (state_q == SHIFT);
  // flush only has meaning between words
  assign det_flush   = flush && (state_q == IDLE);
  assign out_valid   = (state_q == REPORT);
  assign out_count   = word_cnt_q;
  assign total_count = total_q;
  assign busy        = (state_q != IDLE);

  seq_det_core u_core (
    .clk    (clk),
    .reset  (reset),
    .flush  (det_flush),
    .bit_en (bit_en),
    .bit_in (shreg_q[WORD_W-1]),
    .match  (match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      total_q    <= total_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    total_d    = total_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          shreg_d    = in_data;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (match && word_cnt_q != MAXC)
          word_cnt_d = word_cnt_q + CW'(1);
        if (bit_cnt_q == LAST)
          state_d = REPORT;
      end
      REPORT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (match && total_q != '1)
      total_d = total_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl.
// Table of words plus hand sequences for reset and saturation.
module tb_seq_det_ctrl;
  localparam int WORD_W = 8;
  localparam int CNT_W  = 10;
  localparam int TMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WORD_W-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic [3:0]       out_count;
  logic             out_ready;
  logic [CNT_W-1:0] total_count;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;

  seq_det_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_count   (out_count),
    .out_ready   (out_ready),
    .total_count (total_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         pre_fl;
    bit         hs_fl;
    int         bp;
    int         cnt;
    int         tot;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_word(input logic [7:0] d,
                          input bit pre_fl,
                          input bit hs_fl,
                          input bit sh_fl,
                          input int bp,
                          input int ec,
                          input int et);
    int k;
    logic [3:0] held;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_idle", 32'(in_ready), 1);
    if (pre_fl) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = d;
    flush    = hs_fl;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = WORD_W'($urandom);
    flush    = sh_fl;
    chk("busy_shift", 32'(busy), 1);
    chk("in_ready_shift", 32'(in_ready), 0);
    k = 1;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      in_data = WORD_W'($urandom);
      k++;
    end
    chk("latency", k, WORD_W + 1);
    chk("out_count", 32'(out_count), ec);
    chk("total_count", 32'(total_count), et);
    held = out_count;
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_count", 32'(out_count), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 0);
    chk("in_ready_after", 32'(in_ready), 1);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    int exp_t;
    bit bad;

    vecs[0] = '{8'h90, 0, 0, 5, 1, 1};
    vecs[1] = '{8'h92, 0, 0, 0, 2, 3};
    vecs[2] = '{8'h09, 0, 1, 0, 0, 3};
    vecs[3] = '{8'h00, 0, 0, 1, 1, 4};
    vecs[4] = '{8'h09, 0, 0, 0, 0, 4};
    vecs[5] = '{8'h00, 1, 0, 0, 0, 4};
    vecs[6] = '{8'hFF, 0, 0, 2, 0, 4};
    vecs[7] = '{8'h12, 0, 0, 0, 1, 5};
    vecs[8] = '{8'h48, 0, 0, 0, 2, 7};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_total", 32'(total_count), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);

    for (int i = 0; i < 9; i++)
      run_word(vecs[i].data, vecs[i].pre_fl, vecs[i].hs_fl, 1'b0,
               vecs[i].bp, vecs[i].cnt, vecs[i].tot);

    // flush held through SHIFT/REPORT must not clear S4 history
    run_word(8'h09, 0, 0, 1, 2, 0, 7);
    run_word(8'h00, 0, 0, 0, 0, 1, 8);

    // reset in the middle of a word
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h92;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("midrst_no_valid", 32'(bad), 0);
    chk("midrst_total", 32'(total_count), 0);
    chk("midrst_count", 32'(out_count), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    run_word(8'h92, 0, 0, 0, 0, 2, 2);

    // drive total_count into saturation
    exp_t = 2;
    for (int i = 0; i < 515; i++) begin
      exp_t = (exp_t + 2 > TMAX) ? TMAX : exp_t + 2;
      run_word(8'h92, 0, 0, 0, 0, 2, exp_t);
    end
    chk("sat_total", 32'(total_count), TMAX);
    run_word(8'h92, 0, 0, 0, 0, 2, TMAX);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
